// File: rtl/uriscv_alu_issue.sv
// Decode/issue stage feeding the integer ALU. It decodes RV32I ALU-class instructions
// into an op code and A/B operands and holds them in one registered valid/ready slot.
module uriscv_alu_issue #(
    parameter bit RD_ZERO_SUPPRESS = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    input  logic [31:0] in_pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  out_op_o,
    output logic [31:0] out_a_o,
    output logic [31:0] out_b_o,
    output logic [4:0]  out_rd_o,
    output logic        out_rd_wr_o,
    output logic [31:0] out_pc_o,
    output logic        out_illegal_o
);

    localparam logic [3:0] RV_ALU_NONE             = 4'd0;
    localparam logic [3:0] RV_ALU_SHIFTL           = 4'd1;
    localparam logic [3:0] RV_ALU_SHIFTR           = 4'd2;
    localparam logic [3:0] RV_ALU_SHIFTR_ARITH     = 4'd3;
    localparam logic [3:0] RV_ALU_ADD              = 4'd4;
    localparam logic [3:0] RV_ALU_SUB              = 4'd6;
    localparam logic [3:0] RV_ALU_AND              = 4'd7;
    localparam logic [3:0] RV_ALU_OR               = 4'd8;
    localparam logic [3:0] RV_ALU_XOR              = 4'd9;
    localparam logic [3:0] RV_ALU_LESS_THAN        = 4'd10;
    localparam logic [3:0] RV_ALU_LESS_THAN_SIGNED = 4'd11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base op for funct3 when funct7 selects the primary (non-SUB/SRA) variant.
    function automatic logic [3:0] f3_op(input logic [2:0] f3);
        unique case (f3)
            3'd0:    f3_op = RV_ALU_ADD;
            3'd1:    f3_op = RV_ALU_SHIFTL;
            3'd2:    f3_op = RV_ALU_LESS_THAN_SIGNED;
            3'd3:    f3_op = RV_ALU_LESS_THAN;
            3'd4:    f3_op = RV_ALU_XOR;
            3'd5:    f3_op = RV_ALU_SHIFTR;
            3'd6:    f3_op = RV_ALU_OR;
            default: f3_op = RV_ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = in_instr_i[6:0];
    assign funct3 = in_instr_i[14:12];
    assign funct7 = in_instr_i[31:25];
    assign rd     = in_instr_i[11:7];
    assign imm_i  = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    assign imm_u  = {in_instr_i[31:12], 12'b0};
    assign shamt  = {27'b0, in_instr_i[24:20]};

    logic        dec_legal;
    logic [3:0]  dec_op;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_rd_wr;

    // Decode the incoming instruction; illegal encodings collapse to NONE with a=pc, b=0.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = RV_ALU_NONE;
        dec_a     = in_pc_i;
        dec_b     = 32'd0;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_data_i;
                dec_b = rs2_data_i;
                if (funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_op    = f3_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
                    dec_legal = 1'b1;
                    dec_op    = RV_ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
                    dec_legal = 1'b1;
                    dec_op    = RV_ALU_SHIFTR_ARITH;
                end
            end
            OPC_OP_IMM: begin
                dec_a = rs1_data_i;
                if (funct3 == 3'd1) begin
                    dec_legal = (funct7 == F7_BASE);
                    dec_op    = RV_ALU_SHIFTL;
                    dec_b     = shamt;
                end else if (funct3 == 3'd5) begin
                    dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    dec_op    = (funct7 == F7_ALT) ? RV_ALU_SHIFTR_ARITH : RV_ALU_SHIFTR;
                    dec_b     = shamt;
                end else begin
                    dec_legal = 1'b1;
                    dec_op    = f3_op(funct3);
                    dec_b     = imm_i;
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_op    = RV_ALU_ADD;
                dec_a     = 32'd0;
                dec_b     = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_op    = RV_ALU_ADD;
                dec_b     = imm_u;
            end
            OPC_JAL: begin
                dec_legal = 1'b1;
                dec_op    = RV_ALU_ADD;
                dec_b     = 32'd4;
            end
            OPC_JALR: begin
                dec_legal = (funct3 == 3'd0);
                dec_op    = RV_ALU_ADD;
                dec_b     = 32'd4;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_op = RV_ALU_NONE;
            dec_a  = in_pc_i;
            dec_b  = 32'd0;
        end
        dec_rd_wr = dec_legal && !(RD_ZERO_SUPPRESS && rd == 5'd0);
    end

    logic        valid_q;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    logic        rd_wr_q;
    logic [31:0] pc_q;
    logic        illegal_q;
    logic        accept;

    assign in_ready_o = !rst_i && (!valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // Issue slot: reset > flush > accept > consume; fields only change on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            op_q      <= RV_ALU_NONE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rd_q      <= 5'd0;
            rd_wr_q   <= 1'b0;
            pc_q      <= 32'd0;
            illegal_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            op_q      <= dec_op;
            a_q       <= dec_a;
            b_q       <= dec_b;
            rd_q      <= rd;
            rd_wr_q   <= dec_rd_wr;
            pc_q      <= in_pc_i;
            illegal_q <= !dec_legal;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o   = valid_q;
    assign out_op_o      = op_q;
    assign out_a_o       = a_q;
    assign out_b_o       = b_q;
    assign out_rd_o      = rd_q;
    assign out_rd_wr_o   = rd_wr_q;
    assign out_pc_o      = pc_q;
    assign out_illegal_o = illegal_q;

endmodule

// File: tb/tb_uriscv_alu_issue.sv
// Bench for uriscv_alu_issue: directed vector table, handshake corner sequences and
// randomized traffic against a behavioural slot/decode model.
module tb_uriscv_alu_issue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic [3:0]  out_op;
    logic [31:0] out_a, out_b, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_wr, out_illegal;

    always #5 clk = ~clk;

    uriscv_alu_issue dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_instr_i   (in_instr),
        .in_pc_i      (in_pc),
        .rs1_data_i   (rs1_data),
        .rs2_data_i   (rs2_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_op_o     (out_op),
        .out_a_o      (out_a),
        .out_b_o      (out_b),
        .out_rd_o     (out_rd),
        .out_rd_wr_o  (out_rd_wr),
        .out_pc_o     (out_pc),
        .out_illegal_o(out_illegal)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } dec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        dec_t        exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;

    // Model of the issue slot.
    logic m_valid = 1'b0;
    logic m_zero  = 1'b1;
    dec_t m_dec   = '0;
    logic [31:0] m_pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the RV32I instruction rules.
    function automatic dec_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        logic [3:0] base [8];
        dec_t d;
        logic ok;
        logic [6:0] f7;
        logic [2:0] f3;
        base = '{4'd4, 4'd1, 4'd11, 4'd10, 4'd9, 4'd2, 4'd8, 4'd7};
        f7 = i[31:25];
        f3 = i[14:12];
        ok = 1'b0;
        d = '0;
        d.rd = i[11:7];
        case (i[6:0])
            7'h33: begin
                d.a = r1; d.b = r2;
                if (f7 == 7'h00) begin ok = 1; d.op = base[f3]; end
                else if (f7 == 7'h20 && f3 == 0) begin ok = 1; d.op = 4'd6; end
                else if (f7 == 7'h20 && f3 == 5) begin ok = 1; d.op = 4'd3; end
            end
            7'h13: begin
                d.a = r1;
                if (f3 == 1) begin ok = (f7 == 0); d.op = 4'd1; d.b = 32'(i[24:20]); end
                else if (f3 == 5) begin
                    ok = (f7 == 0) || (f7 == 7'h20);
                    d.op = (f7 == 7'h20) ? 4'd3 : 4'd2;
                    d.b = 32'(i[24:20]);
                end else begin
                    ok = 1; d.op = base[f3]; d.b = 32'($signed(i[31:20]));
                end
            end
            7'h37: begin ok = 1; d.op = 4'd4; d.a = 0;  d.b = i & 32'hFFFFF000; end
            7'h17: begin ok = 1; d.op = 4'd4; d.a = pc; d.b = i & 32'hFFFFF000; end
            7'h6F: begin ok = 1; d.op = 4'd4; d.a = pc; d.b = 4; end
            7'h67: begin ok = (f3 == 0); d.op = 4'd4; d.a = pc; d.b = 4; end
            default: ok = 0;
        endcase
        if (!ok) begin d.op = 0; d.a = pc; d.b = 0; end
        d.ill = !ok;
        d.wr  = ok && (d.rd != 0);
        return d;
    endfunction

    task automatic model_edge();
        if (out_valid && out_ready && !rst) xfers++;
        if (rst) begin
            m_valid = 0; m_zero = 1; m_dec = '0; m_pc = '0;
        end else if (flush) begin
            m_valid = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1; m_zero = 0;
            m_dec = ref_decode(in_instr, in_pc, rs1_data, rs2_data);
            m_pc = in_pc;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_model();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("in_ready", 32'(in_ready), 32'(!rst && (!m_valid || out_ready)));
        if (m_valid || m_zero) begin
            chk("op", 32'(out_op), 32'(m_dec.op));
            chk("a", out_a, m_dec.a);
            chk("b", out_b, m_dec.b);
            chk("rd", 32'(out_rd), 32'(m_dec.rd));
            chk("rd_wr", 32'(out_rd_wr), 32'(m_dec.wr));
            chk("illegal", 32'(out_illegal), 32'(m_dec.ill));
            chk("pc", out_pc, m_pc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid = v; in_instr = i; in_pc = pc; rs1_data = r1; rs2_data = r2;
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{32'hFFF08293, 32'h100, 32'h10, 32'h0, '{4'd4, 32'h10, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0}};
        vecs[1]  = '{32'h4020D1B3, 32'h104, 32'h80000000, 32'h7, '{4'd3, 32'h80000000, 32'h7, 5'd3, 1'b1, 1'b0}};
        vecs[2]  = '{32'h4040D193, 32'h108, 32'h80000000, 32'h7, '{4'd3, 32'h80000000, 32'h4, 5'd3, 1'b1, 1'b0}};
        vecs[3]  = '{32'h123453B7, 32'h10C, 32'hDEAD, 32'hBEEF, '{4'd4, 32'h0, 32'h12345000, 5'd7, 1'b1, 1'b0}};
        vecs[4]  = '{32'h00001097, 32'h80000000, 32'h1, 32'h2, '{4'd4, 32'h80000000, 32'h1000, 5'd1, 1'b1, 1'b0}};
        vecs[5]  = '{32'h000000EF, 32'h80000004, 32'h1, 32'h2, '{4'd4, 32'h80000004, 32'h4, 5'd1, 1'b1, 1'b0}};
        vecs[6]  = '{32'h0000007F, 32'h200, 32'h55, 32'h66, '{4'd0, 32'h200, 32'h0, 5'd0, 1'b0, 1'b1}};
        vecs[7]  = '{32'h40109093, 32'h204, 32'h55, 32'h66, '{4'd0, 32'h204, 32'h0, 5'd1, 1'b0, 1'b1}};
        vecs[8]  = '{32'h00208033, 32'h208, 32'h3, 32'h9, '{4'd4, 32'h3, 32'h9, 5'd0, 1'b0, 1'b0}};
        vecs[9]  = '{32'h40C58533, 32'h20C, 32'h100, 32'h1, '{4'd6, 32'h100, 32'h1, 5'd10, 1'b1, 1'b0}};
        vecs[10] = '{32'h0041B133, 32'h210, 32'h1, 32'h2, '{4'd10, 32'h1, 32'h2, 5'd2, 1'b1, 1'b0}};
        vecs[11] = '{32'h000280E7, 32'h214, 32'h9, 32'h9, '{4'd4, 32'h214, 32'h4, 5'd1, 1'b1, 1'b0}};
        vecs[12] = '{32'h000290E7, 32'h218, 32'h9, 32'h9, '{4'd0, 32'h218, 32'h0, 5'd1, 1'b0, 1'b1}};
        vecs[13] = '{32'h4020E1B3, 32'h21C, 32'h1, 32'h2, '{4'd0, 32'h21C, 32'h0, 5'd3, 1'b0, 1'b1}};
        vecs[14] = '{32'hFFF08290, 32'h220, 32'h1, 32'h2, '{4'd0, 32'h220, 32'h0, 5'd5, 1'b0, 1'b1}};
        vecs[15] = '{32'h8000A213, 32'h224, 32'h7, 32'h2, '{4'd11, 32'h7, 32'hFFFFF800, 5'd4, 1'b1, 1'b0}};

        rst = 1; flush = 0; out_ready = 1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(); step();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 0;

        // Directed vectors, back-to-back with the consumer always ready.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
            #1;
            chk("vec_in_ready", 32'(in_ready), 32'd1);
            step();
            chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_op", k), 32'(out_op), 32'(vecs[k].exp.op));
            chk($sformatf("vec%0d_a", k), out_a, vecs[k].exp.a);
            chk($sformatf("vec%0d_b", k), out_b, vecs[k].exp.b);
            chk($sformatf("vec%0d_rd", k), 32'(out_rd), 32'(vecs[k].exp.rd));
            chk($sformatf("vec%0d_wr", k), 32'(out_rd_wr), 32'(vecs[k].exp.wr));
            chk($sformatf("vec%0d_ill", k), 32'(out_illegal), 32'(vecs[k].exp.ill));
            chk($sformatf("vec%0d_pc", k), out_pc, vecs[k].pc);
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: LUI held for 3 stalled cycles, then exactly one transfer.
        out_ready = 0;
        drive(1'b1, 32'h123453B7, 32'h300, 32'h1, 32'h2);
        step();
        drive(1'b1, 32'hFFF08293, 32'h304, 32'h10, 32'h0);
        xfers = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_op", 32'(out_op), 32'd4);
            chk("bp_a", out_a, 32'h0);
            chk("bp_b", out_b, 32'h12345000);
        end
        out_ready = 1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        step();
        chk("bp_xfers", 32'(xfers), 32'd1);

        // Flush with a full slot and a new instruction offered.
        out_ready = 0;
        drive(1'b1, 32'h00208033, 32'h400, 32'h3, 32'h4);
        step();
        chk("fl_fill", 32'(out_valid), 32'd1);
        flush = 1;
        drive(1'b1, 32'h40C58533, 32'h404, 32'h5, 32'h6);
        step();
        chk("fl_valid", 32'(out_valid), 32'd0);
        flush = 0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();

        // Reset with a full slot.
        drive(1'b1, 32'h4020D1B3, 32'h500, 32'h7, 32'h8);
        step();
        chk("rst_fill", 32'(out_valid), 32'd1);
        rst = 1; out_ready = 1;
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_op", 32'(out_op), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        rst = 0;

        // Randomized traffic checked against the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            int sel;
            ins = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: ins[6:0] = 7'h33;
                1: begin ins[6:0] = 7'h33; ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
                2: ins[6:0] = 7'h13;
                3: begin ins[6:0] = 7'h13; ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
                4: ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
                5: ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h6F : 7'h67;
                6: begin ins[6:0] = 7'h67; ins[14:12] = 3'd0; end
                default: ;
            endcase
            drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom);
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 63) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uriscv_alu_issue.md
Name: uriscv_alu_issue

Overview:
- Decode/issue pipeline stage that sits directly upstream of the integer ALU.
- Accepts one fetched instruction per handshake, together with its PC and register-file read data.
- Decodes RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC, JAL, JALR link value) into an ALU op code and A/B operands.
- Presents them from a single registered output slot with a valid/ready handshake to the execute stage.

Parameters:
- RD_ZERO_SUPPRESS, 1, when 1 an instruction with rd==0 issues with out_rd_wr_o=0.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous reset, active-high
- flush_i  input  1  discard held and incoming instruction
- in_valid_i  input  1  instruction/operands valid
- in_ready_o  output  1  stage can accept this cycle
- in_instr_i  input  32  instruction word
- in_pc_i  input  32  instruction PC
- rs1_data_i  input  32  register-file value for instr[19:15]
- rs2_data_i  input  32  register-file value for instr[24:20]
- out_valid_o  output  1  issue slot occupied
- out_ready_i  input  1  execute stage consumes slot
- out_op_o  output  4  ALU op code (`RV_ALU_*`)
- out_a_o  output  32  ALU operand A
- out_b_o  output  32  ALU operand B
- out_rd_o  output  5  destination register
- out_rd_wr_o  output  1  writeback enable
- out_pc_o  output  32  PC of issued instruction
- out_illegal_o  output  1  instruction not decodable

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high.
- Op codes (shared defines): NONE=0, SHIFTL=1, SHIFTR=2, SHIFTR_ARITH=3, ADD=4, SUB=6, AND=7, OR=8, XOR=9, LESS_THAN=10, LESS_THAN_SIGNED=11.
- Reset: all outputs 0 (out_valid_o=0, out_op_o=NONE, operands/pc/rd 0, out_illegal_o=0).
- in_ready_o is combinational: in_ready_o = !out_valid_o || out_ready_i. It is 0 during reset.
- Accept occurs when in_valid_i && in_ready_o. Decoded fields are registered on that edge, so latency is exactly 1 cycle from accept to out_valid_o=1.
- Throughput: 1 instruction/cycle when out_ready_i is held high.
- Backpressure: while out_valid_o && !out_ready_i, every out_* is held stable.
- Consumption: out_valid_o && out_ready_i with no new accept clears out_valid_o next cycle. Consume plus accept in the same cycle loads the new instruction, and out_valid_o stays 1.
- flush_i takes priority over accept: next cycle out_valid_o=0 and the incoming instruction is dropped. in_ready_o is unaffected.
- rst_i overrides flush_i and the handshake.
- Decode for OP (0110011):
  - funct3 0: ADD, or SUB if funct7=0100000.
  - funct3 1: SHIFTL.
  - funct3 2: LESS_THAN_SIGNED.
  - funct3 3: LESS_THAN.
  - funct3 4: XOR.
  - funct3 5: SHIFTR, or SHIFTR_ARITH if funct7=0100000.
  - funct3 6: OR.
  - funct3 7: AND.
  - Operands: a=rs1_data, b=rs2_data.
  - funct7 other than 0000000/0100000, or 0100000 with funct3 not 0/5, is illegal.
- Decode for OP-IMM (0010011):
  - Same mapping, with b = sign-extended instr[31:20]. SUB is never produced.
  - Shifts use b={27'b0,instr[24:20]}.
  - SLLI requires instr[31:25]=0. SRLI/SRAI require instr[31:25] of 0000000/0100000; anything else is illegal.
- LUI: op=ADD, a=0, b={instr[31:12],12'b0}.
- AUIPC: op=ADD, a=in_pc_i, b={instr[31:12],12'b0}.
- JAL and JALR (funct3=0): op=ADD, a=in_pc_i, b=4 (link value). Target computation is not in this block.
- Any other opcode, instr[1:0]!=2'b11, or JALR funct3!=0:
  - out_illegal_o=1, op=NONE, a=in_pc_i, b=0, out_rd_wr_o=0.
  - The instruction is still issued.
- out_rd_o=instr[11:7] for all instructions.
- out_rd_wr_o=1 for legal decodes, except when rd==0 and RD_ZERO_SUPPRESS=1.
- out_pc_o always equals the accepted in_pc_i.
- Outputs are not combinationally dependent on in_*.

Test Plan:
- Reset then ADDI x5,x1,-1 (0xFFF08293), rs1=0x10, in_valid=1, out_ready=1 -> next cycle out_valid=1, op=4, a=0x10, b=0xFFFFFFFF, rd=5, rd_wr=1.
- SRA x3,x1,x2 (0x4020D1B3) then SRAI x3,x1,4 (0x4040D193) back-to-back -> op=3 both cycles; b=rs2_data, then b=4; in_ready stays 1.
- Issue LUI x7,0x12345 (0x123453B7) with out_ready=0 for 3 cycles -> in_ready=0, out_* stable at op=4, a=0, b=0x12345000; release -> consumed, one transfer.
- AUIPC x1,1 (0x00001097) at pc=0x80000000, then JAL x1 at pc=0x80000004 -> b=0x1000, a=0x80000000; then a=0x80000004, b=4.
- Instruction 0x0000007F, and SLLI with instr[30]=1 (0x40109093) -> out_illegal=1, op=0, rd_wr=0.
- ADD x0,x1,x2 -> rd_wr=0. flush_i asserted with in_valid=1 while slot full -> out_valid=0 next cycle. rst_i with slot full -> out_valid=0.
